pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  Receive-side counterpart of the fan PWM generator. Samples a PWM waveform
//  (asynchronous to clk) and recovers its 8-bit duty-cycle code.
//  Used by the smart-home controller to read back fan/cooler speed, and as a
//  loop-back checker on the PWM generator output.
//  Checks each period for length and flags malformed frames.
//  Detects static lines (0% or 100% duty) by timeout.
// PARAMETERS
//  PERIOD   256  nominal PWM period in clk cycles (generator frame length)
//  TOL      4    allowed |measured period - PERIOD|, in clk cycles
//  TIMEOUT  512  cycles without a rising edge before the line is declared static
//  CW       16   width of internal counters; counters saturate at 2^CW-1
// PORTS
//  clk         in   1  clock, posedge
//  arst        in   1  reset, SYNCHRONOUS, active-high
//  pwm_in      in   1  PWM line, asynchronous to clk
//  duty        out  8  last recovered duty code (0..255)
//  duty_valid  out  1  one-cycle pulse: duty was just updated
//  period_err  out  1  one-cycle pulse: last period was out of tolerance
//  line_static out  1  level: no rising edge for TIMEOUT cycles
// BEHAVIOUR
//  Reset (arst high at posedge): all outputs 0, all counters 0, state IDLE.
//   The synchroniser flops are cleared to 0.
//   Reset overrides every other event in the same cycle.
//  Sync: s1<=pwm_in; s2<=s1; s3<=s2. rise = s2 & ~s3 (combinational).
//  Counters, updated at posedges while in MEASURE:
//   per_cnt: set to 1 on rise, else +1 (saturating).
//   hi_cnt:  set to 1 on rise, else +s2 (saturating).
//  FSM states:
//   IDLE     wait for the first rise -> MEASURE. No outputs are produced.
//            A partial first period is never reported.
//   MEASURE  on rise: P=per_cnt, H=hi_cnt (values before reload).
//            If |P-PERIOD|<=TOL: duty<=min(H,255), duty_valid<=1.
//            Otherwise: period_err<=1 and duty holds its value.
//            Both counters reload to 1; stay in MEASURE.
//            If per_cnt reaches TIMEOUT with no rise -> STATIC. In that cycle:
//            duty<=s2 ? 255 : 0, duty_valid<=1, line_static<=1.
//   STATIC   line_static stays 1. No further pulses are produced.
//            On rise: line_static<=0, counters load 1, -> MEASURE.
//            The period that follows is measured as normal.
//  Latency: pwm_in rising is sampled by s1 at edge k. duty, duty_valid and
//   period_err are registered at edge k+2, covering the period that just ended.
//  duty_valid and period_err are never high together.
//   Each is high for exactly one cycle per event.
//  A rise at the same edge as the timeout threshold counts as a rise.
//   No timeout is taken.
//  Input pulses shorter than one clk may be missed. This is not an error.
//  Glitches that produce extra rises show up as short periods and set
//   period_err.
// TESTING
//  1. Reset released; PWM 64 high / 192 low repeating ->
//     1st rise: no pulse; each later rise: duty=64 with duty_valid, period_err=0.
//  2. Duty sweep 1, 128, 255 high-cycles per 256-cycle frame ->
//     duty=1, then 128, then 255. Check latency of exactly 2 clk after the s1 sample.
//  3. Line held low after a valid frame -> 512 cycles after the last rise:
//     duty=0, duty_valid pulse, line_static=1.
//     Held high instead -> duty=255 at the same point.
//  4. Periods of 300 and 252 cycles, both with 100 high ->
//     300: period_err pulse, duty unchanged. 252: duty=100 with duty_valid.
//  5. arst asserted mid-period while duty=64 ->
//     duty=0 and all flags 0 at the next edge.
//     The first rise after release gives no output; the second gives duty=64.
//  6. STATIC (line high), then 64/192 frames resume ->
//     line_static clears on the first rise; the next rise gives duty=64.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Purpose: recovers the 8-bit duty code from an asynchronous PWM line, flags off-length periods and static lines.
// Latency: duty/duty_valid/period_err are registered 2 clk after pwm_in's rising edge is first sampled.
// Backpressure: none; results are single-cycle pulses with no ready, and a missed pulse is simply overwritten.
module pwm_duty_decoder #(
  parameter int PERIOD  = 256,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 512,
  parameter int CW      = 16
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       pwm_in,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic       period_err,
  output logic       line_static
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STATIC  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] PER_LO    = CW'(PERIOD - TOL);
  localparam logic [CW-1:0] PER_HI    = CW'(PERIOD + TOL);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] DUTY_CAP  = CW'(255);

  state_t        state_q, state_d;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          duty_valid_q, duty_valid_d;
  logic          period_err_q, period_err_d;
  logic          line_static_q, line_static_d;

  logic          rise;
  logic          in_tol;
  logic [CW-1:0] per_inc;
  logic [CW-1:0] hi_inc;
  logic [7:0]    duty_sat;

  // Three-flop synchroniser; the third flop only exists to spot the 0->1 step on s2.
  always_ff @(posedge clk) begin
    if (arst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Counter values before reload describe the period that ends at this rise.
  assign in_tol   = (per_cnt_q >= PER_LO) && (per_cnt_q <= PER_HI);
  assign per_inc  = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + ONE;
  assign hi_inc   = (s2_q && (hi_cnt_q != CNT_MAX)) ? hi_cnt_q + ONE : hi_cnt_q;
  assign duty_sat = (hi_cnt_q > DUTY_CAP) ? 8'hFF : hi_cnt_q[7:0];

  // Next-state: frame measurement, tolerance check and static-line timeout.
  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    hi_cnt_d      = hi_cnt_q;
    duty_d        = duty_q;
    duty_valid_d  = 1'b0;
    period_err_d  = 1'b0;
    line_static_d = line_static_q;

    case (state_q)
      IDLE: begin
        // The partial period before the first rise is discarded.
        if (rise) begin
          per_cnt_d = ONE;
          hi_cnt_d  = ONE;
          state_d   = MEASURE;
        end
      end

      MEASURE: begin
        // A rise landing on the timeout edge wins: it closes a (long) period.
        if (rise) begin
          if (in_tol) begin
            duty_d       = duty_sat;
            duty_valid_d = 1'b1;
          end else begin
            period_err_d = 1'b1;
          end
          per_cnt_d = ONE;
          hi_cnt_d  = ONE;
        end else if (per_cnt_q >= TIMEOUT_C) begin
          duty_d        = s2_q ? 8'hFF : 8'h00;
          duty_valid_d  = 1'b1;
          line_static_d = 1'b1;
          state_d       = STATIC;
        end else begin
          per_cnt_d = per_inc;
          hi_cnt_d  = hi_inc;
        end
      end

      STATIC: begin
        // Leaving STATIC starts a fresh period; nothing is reported for the stall.
        if (rise) begin
          line_static_d = 1'b0;
          per_cnt_d     = ONE;
          hi_cnt_d      = ONE;
          state_d       = MEASURE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset beats any same-cycle event.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q       <= IDLE;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      duty_q        <= 8'h00;
      duty_valid_q  <= 1'b0;
      period_err_q  <= 1'b0;
      line_static_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      duty_q        <= duty_d;
      duty_valid_q  <= duty_valid_d;
      period_err_q  <= period_err_d;
      line_static_q <= line_static_d;
    end
  end

  assign duty        = duty_q;
  assign duty_valid  = duty_valid_q;
  assign period_err  = period_err_q;
  assign line_static = line_static_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Purpose: directed PWM frames with hand-computed duty codes, checked by a queue-based scoreboard.
// Latency: an expected event is due 3 edges after the driver raises pwm_in (1 to s1, 2 more to outputs).
// Backpressure: none; the monitor pops one expectation per duty_valid/period_err pulse.
module tb_pwm_duty_decoder;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;
  localparam int LAT     = 3;
  localparam int TO_LAT  = 512 + LAT;

  typedef struct {
    int kind;
    int duty;
    int cyc;
    int ls;
  } exp_t;

  logic       clk;
  logic       arst;
  logic       pwm_in;
  logic [7:0] duty;
  logic       duty_valid;
  logic       period_err;
  logic       line_static;

  int   cyc;
  int   n_run;
  int   n_fail;
  exp_t sb[$];

  pwm_duty_decoder dut (
    .clk         (clk),
    .arst        (arst),
    .pwm_in      (pwm_in),
    .duty        (duty),
    .duty_valid  (duty_valid),
    .period_err  (period_err),
    .line_static (line_static)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after posedge N, cyc == N.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one frame: rise, hi cycles high, lo cycles low. Expectations for the
  // period that this rise closes (and an optional timeout after it) go in first.
  task automatic pulse(input int hi, input int lo, input int kind, input int d, input int to_d);
    exp_t e;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.duty = d;
      e.cyc  = cyc + LAT;
      e.ls   = 0;
      sb.push_back(e);
    end
    if (to_d >= 0) begin
      e.kind = K_VALID;
      e.duty = to_d;
      e.cyc  = cyc + TO_LAT;
      e.ls   = 1;
      sb.push_back(e);
    end
    pwm_in = 1'b1;
    repeat (hi) begin
      @(posedge clk);
      #1;
    end
    pwm_in = lo > 0 ? 1'b0 : 1'b1;
    repeat (lo) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (duty_valid || period_err) begin
      chk("exclusive", {31'd0, duty_valid & period_err}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, period_err, duty_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("kind", duty_valid ? K_VALID : K_ERR, e.kind);
        chk("duty", {24'd0, duty}, e.duty);
        chk("latency_cycle", cyc, e.cyc);
        chk("line_static_at_pulse", {31'd0, line_static}, e.ls);
      end
    end
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    arst   = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_duty", {24'd0, duty}, 0);
    chk("reset_duty_valid", {31'd0, duty_valid}, 0);
    chk("reset_period_err", {31'd0, period_err}, 0);
    chk("reset_line_static", {31'd0, line_static}, 0);
    arst = 1'b0;
    hold(1'b0, 5);

    // 64/192 frames: first rise silent, later rises report 64.
    pulse(64, 192, K_NONE, 0, -1);
    pulse(64, 192, K_VALID, 64, -1);
    pulse(64, 192, K_VALID, 64, -1);
    pulse(64, 192, K_VALID, 64, -1);

    // Duty sweep 1, 128, 255 (each reported at the following rise).
    pulse(1, 255, K_VALID, 64, -1);
    pulse(128, 128, K_VALID, 1, -1);
    pulse(255, 1, K_VALID, 128, -1);
    pulse(64, 192, K_VALID, 255, -1);

    // 300-cycle period -> error, duty holds; 252-cycle period -> accepted.
    pulse(100, 200, K_VALID, 64, -1);
    pulse(100, 152, K_ERR, 64, -1);
    pulse(64, 192, K_VALID, 100, 0);

    // Line stays low after that rise: timeout reports duty 0 and goes static.
    hold(1'b0, 400);
    chk("static_low_ls", {31'd0, line_static}, 1);
    chk("static_low_duty", {24'd0, duty}, 0);

    // Resume from STATIC, then hold high after a valid frame.
    pulse(64, 192, K_NONE, 0, -1);
    chk("static_exit_ls", {31'd0, line_static}, 0);
    pulse(64, 192, K_VALID, 64, -1);
    pulse(600, 0, K_VALID, 64, 255);
    chk("static_high_ls", {31'd0, line_static}, 1);
    chk("static_high_duty", {24'd0, duty}, 255);

    // STATIC high, then 64/192 frames resume.
    hold(1'b0, 50);
    chk("static_hold_ls", {31'd0, line_static}, 1);
    pulse(64, 192, K_NONE, 0, -1);
    chk("resume_ls", {31'd0, line_static}, 0);
    pulse(64, 192, K_VALID, 64, -1);

    // Reset in the middle of a period while duty=64.
    pulse(64, 100, K_VALID, 64, -1);
    chk("pre_reset_duty", {24'd0, duty}, 64);
    arst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_duty", {24'd0, duty}, 0);
    chk("midreset_flags", {29'd0, duty_valid, period_err, line_static}, 0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    hold(1'b0, 5);
    pulse(64, 192, K_NONE, 0, -1);
    pulse(64, 192, K_VALID, 64, -1);
    hold(1'b0, 10);

    // Drain: every expectation must have been consumed within a bounded wait.
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
